// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   pc_src_e      : next-PC source select (sequential / jump / branch / reserved)
//   INSTR_NOP     : instruction word presented when no instruction is available
//   fetch_entry_t : one fetch-queue slot at the default 32-bit width
//   is_redirect() : true when the PC source abandons sequential fetch
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int FETCH_XLEN = 32;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_JUMP   = 2'b01,
    PC_BRANCH = 2'b10,
    PC_RSVD   = 2'b11   // behaves exactly like PC_SEQ
  } pc_src_e;

  localparam logic [FETCH_XLEN-1:0] INSTR_NOP = '0;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] inst;
    logic                  filled;
  } fetch_entry_t;

  function automatic logic is_redirect(input pc_src_e src);
    return (src == PC_JUMP) || (src == PC_BRANCH);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// DEPTH-entry ring buffer holding fetches from allocation (request issued)
// until decode pops them. Three pointers walk the ring in the same order:
//   alloc : next slot to hand to a new imem request
//   fill  : oldest allocated slot still waiting for its imem response
//   head  : oldest slot, presented to decode
// A slot is live from alloc until pop; count tracks live slots and pend
// tracks live-but-unfilled slots (fetches still in flight).
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   flush_i             drop every slot and rewind all pointers (wins over all)
//   alloc_i/alloc_pc_i  allocate a slot for a request issued at this PC
//   fill_i/fill_inst_i  write the returning word into the fill slot
//   pop_i               retire the head slot (only when head is filled)
//   count_o             live slots
//   pend_o              live slots still awaiting their response
//   head_filled_o       head slot holds a returned instruction
//   head_pc_o/inst_o    head slot contents, zero when the queue is empty
// ---------------------------------------------------------------------------
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       alloc_i,
  input  logic [XLEN-1:0]            alloc_pc_i,
  input  logic                       fill_i,
  input  logic [XLEN-1:0]            fill_inst_i,
  input  logic                       pop_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [$clog2(DEPTH+1)-1:0] pend_o,
  output logic                       head_filled_o,
  output logic [XLEN-1:0]            head_pc_o,
  output logic [XLEN-1:0]            head_inst_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            filled;
  } entry_t;

  entry_t          entry_q [DEPTH];
  logic [PW-1:0]   alloc_q;
  logic [PW-1:0]   fill_q;
  logic [PW-1:0]   head_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   pend_q;

  // Pointers are PW bits wide and DEPTH is a power of two, so the
  // natural increment overflow is the ring wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      alloc_q <= '0;
      fill_q  <= '0;
      head_q  <= '0;
      count_q <= '0;
      pend_q  <= '0;
    end else if (flush_i) begin
      // Clearing filled is what invalidates the slots; pc/inst are don't-care.
      for (int i = 0; i < DEPTH; i++) entry_q[i].filled <= 1'b0;
      alloc_q <= '0;
      fill_q  <= '0;
      head_q  <= '0;
      count_q <= '0;
      pend_q  <= '0;
    end else begin
      // pop, alloc and fill never target the same slot in one cycle:
      // pop needs a filled head, fill needs an unfilled slot, and alloc
      // only lands on the head slot when the queue is empty.
      if (pop_i) begin
        entry_q[head_q].filled <= 1'b0;
        head_q                 <= head_q + 1'b1;
      end
      if (alloc_i) begin
        entry_q[alloc_q].pc     <= alloc_pc_i;
        entry_q[alloc_q].inst   <= XLEN'(INSTR_NOP);
        entry_q[alloc_q].filled <= 1'b0;
        alloc_q                 <= alloc_q + 1'b1;
      end
      if (fill_i) begin
        entry_q[fill_q].inst   <= fill_inst_i;
        entry_q[fill_q].filled <= 1'b1;
        fill_q                 <= fill_q + 1'b1;
      end
      count_q <= count_q + CW'(alloc_i) - CW'(pop_i);
      pend_q  <= pend_q + CW'(alloc_i) - CW'(fill_i);
    end
  end

  assign count_o       = count_q;
  assign pend_o        = pend_q;
  assign head_filled_o = entry_q[head_q].filled;
  assign head_pc_o     = (count_q != '0) ? entry_q[head_q].pc   : '0;
  assign head_inst_o   = (count_q != '0) ? entry_q[head_q].inst : XLEN'(INSTR_NOP);

endmodule

// File: rtl/fetch_queue_stage.sv
// ---------------------------------------------------------------------------
// fetch_queue_stage
// Instruction-fetch stage between an in-order instruction memory and decode.
// Owns the PC, picks the next PC (sequential / jump / branch), issues one
// pipelined imem request per cycle while queue space remains, buffers the
// returned words with their PC, and offers {pc, inst} to decode.
//
// Handshake: out_valid means the head entry holds a returned instruction;
// the entry transfers on any rising edge where out_valid && out_ready, and
// out_pc/out_inst stay stable while out_valid is high and out_ready low
// (only a redirect withdraws an offered entry). imem_req has no ready: imem
// accepts every request and answers in request order, at least one cycle
// later, on imem_rvalid.
//
// A redirect (jump or branch) flushes the queue in the same cycle. Requests
// already in flight still return; discard_q counts them so they are dropped
// instead of filling slots that now belong to the new path.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   pc_src                    00 seq, 01 jump, 10 branch, 11 treated as seq
//   jump_addr, branch_addr    redirect targets
//   imem_req, imem_addr       fetch request and address (= current PC)
//   imem_rvalid, imem_rdata   in-order fetch response
//   out_valid/out_ready       decode handshake
//   out_pc, out_inst          head entry, zero when the queue is empty
//   perf_fetched/dropped/stall  saturating event counters, present only
//                               when FETCH_PERF_EN is defined
//
// Build option: define FETCH_PERF_EN to add the performance counters.
// ---------------------------------------------------------------------------
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] jump_addr,
  input  logic [XLEN-1:0] branch_addr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped,
  output logic [31:0]     perf_stall
`endif
);

  localparam int CW = $clog2(DEPTH+1);
  // Discards from one redirect plus requests issued before the next can
  // exceed DEPTH when imem latency is long; two spare bits give headroom.
  localparam int DW = CW + 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(XLEN/8);

  pc_src_e         src;
  logic            redirect;
  logic [XLEN-1:0] target;
  logic            full;
  logic            issue;
  logic            drop;
  logic            fill;
  logic            pop;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [DW-1:0]   discard_q, discard_d;
  // Holds imem_req low in the first cycle after reset release.
  logic            run_q;

  logic [CW-1:0]   count;
  logic [CW-1:0]   pend;
  logic            head_filled;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_inst;

  // ---------------- control ----------------
  assign src      = pc_src_e'(pc_src);
  assign redirect = is_redirect(src);
  assign full     = (count == CW'(DEPTH));
  assign issue    = run_q && !redirect && !full;
  assign drop     = imem_rvalid && (discard_q != '0);
  // On a redirect the queue is flushed, so a live response is thrown away.
  assign fill     = imem_rvalid && (discard_q == '0) && !redirect;
  assign pop      = out_valid && out_ready;

  always_comb begin
    target = pc_q;
    case (src)
      PC_JUMP:   target = jump_addr;
      PC_BRANCH: target = branch_addr;
      default:   target = pc_q;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect)   pc_d = target;
    else if (issue) pc_d = pc_q + PC_STEP;   // wraps modulo 2^XLEN
  end

  // Everything still owed by imem (live in-flight plus already-condemned)
  // becomes discardable on a redirect, less the word arriving right now.
  always_comb begin
    discard_d = discard_q;
    if (redirect)  discard_d = discard_q + DW'(pend) - DW'(imem_rvalid);
    else if (drop) discard_d = discard_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      discard_q <= '0;
      run_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      discard_q <= discard_d;
      run_q     <= 1'b1;
    end
  end

  // ---------------- queue ----------------
  fetch_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (redirect),
    .alloc_i       (issue),
    .alloc_pc_i    (pc_q),
    .fill_i        (fill),
    .fill_inst_i   (imem_rdata),
    .pop_i         (pop),
    .count_o       (count),
    .pend_o        (pend),
    .head_filled_o (head_filled),
    .head_pc_o     (head_pc),
    .head_inst_o   (head_inst)
  );

  // ---------------- outputs ----------------
  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign out_valid = head_filled && !redirect;
  assign out_pc    = head_pc;
  assign out_inst  = head_inst;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_dropped_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (pop  && (perf_fetched_q != '1)) perf_fetched_q <= perf_fetched_q + 1'b1;
      if (drop && (perf_dropped_q != '1)) perf_dropped_q <= perf_dropped_q + 1'b1;
      if (full && (perf_stall_q   != '1)) perf_stall_q   <= perf_stall_q + 1'b1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
  assign perf_stall   = perf_stall_q;
`endif

  // A response with nothing allocated or condemned means imem broke order.
  a_rvalid_expected: assert property (
    @(posedge clk) disable iff (!rst)
      imem_rvalid |-> ((pend != '0) || (discard_q != '0))
  );

endmodule
